// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB front end of the synchronous FIFO:
// register offsets, STATUS bit positions and the read-handshake FSM states.
package apb_fifo_pkg;

  localparam int unsigned DATA_OFF   = 'h0;
  localparam int unsigned STATUS_OFF = 'h4;
  localparam int unsigned THRESH_OFF = 'h8;
  localparam int unsigned IRQEN_OFF  = 'hC;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_UNF     = 3;
  localparam int unsigned ST_LVL_LSB = 8;

  localparam int unsigned IE_LEVEL = 0;
  localparam int unsigned IE_ERR   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/apb_fifo_completer.sv
// APB3 completer fronting an external synchronous FIFO: DATA push/pop,
// status with sticky errors, locally tracked level and a threshold interrupt.
module apb_fifo_completer
  import apb_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  state_t           state;
  logic [LVL_W-1:0] level;
  logic             ovf, unf;
  logic [7:0]       thresh;
  logic [1:0]       irq_en;

  logic             access;
  logic [ADDR_W-1:0] off;
  logic             hit_data, hit_status, hit_thresh, hit_irqen, mapped;
  logic [31:0]      reg_rdata;
  logic             unused_bits;

  assign access     = psel & penable;
  assign off        = {paddr[ADDR_W-1:2], 2'b00};
  assign hit_data   = (off == ADDR_W'(DATA_OFF));
  assign hit_status = (off == ADDR_W'(STATUS_OFF));
  assign hit_thresh = (off == ADDR_W'(THRESH_OFF));
  assign hit_irqen  = (off == ADDR_W'(IRQEN_OFF));
  assign mapped     = hit_data | hit_status | hit_thresh | hit_irqen;
  assign fifo_din   = pwdata[DATA_W-1:0];
  assign unused_bits = ^{paddr[1:0], pwdata[31:8]};

  // Non-DATA register read mux; DATA reads are served by the FSM.
  always_comb begin
    reg_rdata = '0;
    if (hit_status) begin
      reg_rdata[ST_EMPTY] = fifo_empty;
      reg_rdata[ST_FULL]  = fifo_full;
      reg_rdata[ST_OVF]   = ovf;
      reg_rdata[ST_UNF]   = unf;
      reg_rdata[ST_LVL_LSB +: 8] = 8'(level);
    end else if (hit_thresh) begin
      reg_rdata[7:0] = thresh;
    end else if (hit_irqen) begin
      reg_rdata[1:0] = irq_en;
    end
  end

  // Bus responses are combinational so writes finish in the first access
  // cycle; gating with rst_n makes them collapse as soon as reset asserts.
  always_comb begin
    pready     = 1'b0;
    pslverr    = 1'b0;
    prdata     = '0;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    if (rst_n && access) begin
      unique case (state)
        IDLE: begin
          if (!mapped) begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end else if (pwrite) begin
            pready = 1'b1;
            if (hit_data) begin
              if (fifo_full) pslverr    = 1'b1;
              else           fifo_wr_en = 1'b1;
            end
          end else if (hit_data) begin
            if (fifo_empty) begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end else begin
              fifo_rd_en = 1'b1;
            end
          end else begin
            pready = 1'b1;
            prdata = reg_rdata;
          end
        end
        POP: begin
          pready = 1'b1;
          prdata = 32'(fifo_dout);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      level  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      thresh <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (fifo_rd_en) state <= POP;
        POP: begin
          state <= DONE;
          if (level != '0) level <= level - 1'b1;
        end
        DONE: if (!access) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fifo_wr_en && level < LVL_W'(DEPTH)) level <= level + 1'b1;

      if (access && state == IDLE && mapped) begin
        if (pwrite) begin
          if (hit_data && fifo_full) ovf <= 1'b1;
          if (hit_status) begin
            if (pwdata[ST_OVF]) ovf <= 1'b0;
            if (pwdata[ST_UNF]) unf <= 1'b0;
          end
          if (hit_thresh) thresh <= pwdata[7:0];
          if (hit_irqen)  irq_en <= pwdata[1:0];
        end else if (hit_data && fifo_empty) begin
          unf <= 1'b1;
        end
      end

      irq <= (irq_en[IE_LEVEL] && thresh != '0 && 32'(level) >= 32'(thresh)) ||
             (irq_en[IE_ERR] && (ovf || unf));
    end
  end

endmodule

// File: tb/tb_apb_fifo_completer.sv
// Directed bench for apb_fifo_completer with a behavioural 16x8 FIFO and a
// queue of expected pop data.
module tb_apb_fifo_completer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        fifo_wr_en, fifo_rd_en;
  logic [7:0]  fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  apb_fifo_completer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .irq(irq)
  );

  // Behavioural FIFO: registered dout, shares rst_n with the completer.
  logic [7:0] fmem [16];
  int fwp, frp, fcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp <= 0; frp <= 0; fcnt <= 0; fifo_dout <= '0;
    end else begin
      if (fifo_wr_en && fcnt < 16) begin
        fmem[fwp] <= fifo_din;
        fwp <= (fwp + 1) % 16;
      end
      if (fifo_rd_en && fcnt > 0) begin
        fifo_dout <= fmem[frp];
        frp <= (frp + 1) % 16;
      end
      fcnt <= fcnt + ((fifo_wr_en && fcnt < 16) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
    end
  end
  assign fifo_full  = (fcnt == 16);
  assign fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (fifo_wr_en === 1'b1) wr_pulses <= wr_pulses + 1;
    if (fifo_rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; waits = 0; #1;
    while (pready !== 1'b1 && waits < 8) begin
      waits++;
      @(posedge clk); #2;
    end
    check("pready_seen", 32'(pready), 32'd1);
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [3:0] a, input logic [31:0] d,
                        input logic exp_err);
    logic [31:0] rd; logic err; int waits, w0;
    w0 = wr_pulses;
    apb(1'b1, a, d, rd, err, waits);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_wait"}, 32'(waits), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_pulses - w0), (a == 4'h0 && !exp_err) ? 32'd1 : 32'd0);
    if (a == 4'h0 && !exp_err) exp_q.push_back({24'b0, d[7:0]});
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic err; int waits;
    apb(1'b0, a, 32'h0, rd, err, waits);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] rd; logic err; int waits, r0;
    logic [31:0] exp;
    logic was_empty;
    was_empty = (exp_q.size() == 0);
    exp = was_empty ? 32'h0 : exp_q.pop_front();
    r0 = rd_pulses;
    apb(1'b0, 4'h0, 32'h0, rd, err, waits);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(err), 32'(was_empty));
    check({tag, "_wait"}, 32'(waits), was_empty ? 32'd0 : 32'd1);
    check({tag, "_rd_en"}, 32'(rd_pulses - r0), was_empty ? 32'd0 : 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    idle(3);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_strobes", {30'b0, fifo_wr_en, fifo_rd_en}, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    idle(1);
    rd_reg("status_rst", 4'h4, 32'h0000_0001);
    check("irq_idle", 32'(irq), 32'd0);

    // Two pushes, two pops.
    wr_reg("push_a5", 4'h0, 32'h0000_00A5, 1'b0);
    wr_reg("push_3c", 4'h0, 32'hFFFF_FF3C, 1'b0);
    rd_reg("status_lvl2", 4'h4, 32'h0000_0200);
    rd_data("pop_a5");
    rd_data("pop_3c");
    rd_reg("status_empty", 4'h4, 32'h0000_0001);

    // Fill, overflow, W1C ovf, drain.
    for (int i = 0; i < 16; i++) wr_reg("fill", 4'h0, 32'(i * 13 + 7), 1'b0);
    wr_reg("push_ovf", 4'h0, 32'h0000_00FF, 1'b1);
    rd_reg("status_full_ovf", 4'h4, 32'h0000_1006);
    wr_reg("w1c_ovf", 4'h4, 32'h0000_0004, 1'b0);
    rd_reg("status_full", 4'h4, 32'h0000_1002);
    for (int i = 0; i < 16; i++) rd_data("drain");
    rd_reg("status_drained", 4'h4, 32'h0000_0001);

    // Underflow and error interrupt.
    rd_data("pop_empty");
    rd_reg("status_unf", 4'h4, 32'h0000_0009);
    wr_reg("irqen_err", 4'hC, 32'h0000_0002, 1'b0);
    idle(2);
    check("irq_unf", 32'(irq), 32'd1);
    wr_reg("w1c_unf", 4'h4, 32'h0000_0008, 1'b0);
    idle(2);
    check("irq_unf_clr", 32'(irq), 32'd0);

    // Level threshold interrupt.
    wr_reg("thresh4", 4'h8, 32'h0000_0104, 1'b0);
    wr_reg("irqen_lvl", 4'hC, 32'h0000_0001, 1'b0);
    rd_reg("thresh_rb", 4'h8, 32'h0000_0004);
    rd_reg("irqen_rb", 4'hC, 32'h0000_0001);
    for (int i = 0; i < 3; i++) wr_reg("thr_push", 4'h0, 32'(8'h40 + i), 1'b0);
    idle(2);
    check("irq_lvl3", 32'(irq), 32'd0);
    wr_reg("thr_push4", 4'h0, 32'h0000_0043, 1'b0);
    idle(2);
    check("irq_lvl4", 32'(irq), 32'd1);
    rd_data("thr_pop");
    idle(2);
    check("irq_lvl3_again", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) rd_data("thr_drain");

    // Reset during the POP cycle of a DATA read.
    wr_reg("push_77", 4'h0, 32'h0000_0077, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(posedge clk); #1;
    penable = 1'b1; #1;
    check("mid_first_pready", 32'(pready), 32'd0);
    check("mid_first_rd_en", 32'(fifo_rd_en), 32'd1);
    @(posedge clk); #1;
    check("mid_pop_pready", 32'(pready), 32'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_pready", 32'(pready), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    exp_q.delete();
    psel = 1'b0; penable = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd_reg("status_post_rst", 4'h4, 32'h0000_0001);
    wr_reg("push_5a", 4'h0, 32'h0000_005A, 1'b0);
    rd_data("pop_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
